// File: rtl/ex_muldiv_if.sv
// Execute-stage handshake between the decode/execute pipeline register and the
// iterative multiply/divide unit.
interface ex_muldiv_if #(parameter int XLEN = 32);
  logic            de2ex_inst_valid_ffout;
  logic            de2ex_MD_OP_ffout;
  logic [2:0]      de2ex_aluop_ffout;
  logic [XLEN-1:0] de2ex_rd_oprand1_ffout;
  logic [XLEN-1:0] de2ex_rd_oprand2_ffout;
  logic [4:0]      de2ex_wr_regindex_ffout;
  logic            ex_flush;
  logic            md2ex_busy;
  logic            md2ex_valid;
  logic [XLEN-1:0] md2ex_wdata;
  logic [4:0]      md2ex_regindex;

  modport master (
    output de2ex_inst_valid_ffout, de2ex_MD_OP_ffout, de2ex_aluop_ffout,
           de2ex_rd_oprand1_ffout, de2ex_rd_oprand2_ffout, de2ex_wr_regindex_ffout,
           ex_flush,
    input  md2ex_busy, md2ex_valid, md2ex_wdata, md2ex_regindex
  );

  modport slave (
    input  de2ex_inst_valid_ffout, de2ex_MD_OP_ffout, de2ex_aluop_ffout,
           de2ex_rd_oprand1_ffout, de2ex_rd_oprand2_ffout, de2ex_wr_regindex_ffout,
           ex_flush,
    output md2ex_busy, md2ex_valid, md2ex_wdata, md2ex_regindex
  );
endinterface

// File: rtl/ex_muldiv.sv
// Iterative RISC-V M-extension unit: shift-add multiply and restoring divide on
// operand magnitudes, UNROLL result bits per cycle, sign fixed up at the end.
//
// state | meaning
// IDLE  | waiting for an M op; special-case divides resolve here directly
// CALC  | iterating, counter runs XLEN/UNROLL down to 1
// DONE  | one-cycle result strobe, pipeline advances
module ex_muldiv #(
  parameter int XLEN   = 32,
  parameter int UNROLL = 1
) (
  input logic       clk,
  input logic       reset,
  ex_muldiv_if.slave bus
);
  localparam int STEPS = XLEN / UNROLL;
  localparam int CW    = $clog2(STEPS + 1);
  localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   cnt;
  logic [2:0]      op;
  logic [XLEN-1:0] acc_hi, acc_lo, opb;
  logic            neg_q, neg_r;
  logic [4:0]      rd_q;
  logic            valid_q;
  logic [XLEN-1:0] wdata_q;
  logic [4:0]      regindex_q;

  logic            start;
  logic [2:0]      f3;
  logic [XLEN-1:0] a, b, abs_a, abs_b, special_res;
  logic            sa, sb, special;

  assign start = bus.de2ex_inst_valid_ffout & bus.de2ex_MD_OP_ffout & ~bus.ex_flush;
  assign f3    = bus.de2ex_aluop_ffout;
  assign a     = bus.de2ex_rd_oprand1_ffout;
  assign b     = bus.de2ex_rd_oprand2_ffout;

  // MUL keeps raw operands: its low half is sign-agnostic.
  assign sa    = (f3 == 3'd1) | (f3 == 3'd2) | (f3 == 3'd4) | (f3 == 3'd6);
  assign sb    = (f3 == 3'd1) | (f3 == 3'd4) | (f3 == 3'd6);
  assign abs_a = (sa & a[XLEN-1]) ? -a : a;
  assign abs_b = (sb & b[XLEN-1]) ? -b : b;

  always_comb begin
    special     = 1'b0;
    special_res = '0;
    if (f3[2] && b == '0) begin
      special     = 1'b1;
      special_res = f3[1] ? a : '1;
    end else if (f3[2] && !f3[0] && a == MOST_NEG && b == '1) begin
      special     = 1'b1;
      special_res = f3[1] ? '0 : MOST_NEG;
    end
  end

  logic [XLEN-1:0]   hi_n, lo_n;
  logic [XLEN:0]     sum, rsh, diff;
  logic [2*XLEN-1:0] prod, prod_s;
  logic [XLEN-1:0]   res;

  always_comb begin
    hi_n = acc_hi;
    lo_n = acc_lo;
    sum  = '0;
    rsh  = '0;
    diff = '0;
    for (int i = 0; i < UNROLL; i++) begin
      if (!op[2]) begin
        sum  = {1'b0, hi_n} + (lo_n[0] ? {1'b0, opb} : '0);
        lo_n = {sum[0], lo_n[XLEN-1:1]};
        hi_n = sum[XLEN:1];
      end else begin
        // Remainder stays below the divisor, so the borrow bit alone decides.
        rsh  = {hi_n, lo_n[XLEN-1]};
        diff = rsh - {1'b0, opb};
        if (!diff[XLEN]) begin
          hi_n = diff[XLEN-1:0];
          lo_n = {lo_n[XLEN-2:0], 1'b1};
        end else begin
          hi_n = rsh[XLEN-1:0];
          lo_n = {lo_n[XLEN-2:0], 1'b0};
        end
      end
    end
    prod   = {hi_n, lo_n};
    prod_s = neg_q ? -prod : prod;
    case (op)
      3'd0:                res = prod_s[XLEN-1:0];
      3'd1, 3'd2, 3'd3:    res = prod_s[2*XLEN-1:XLEN];
      3'd4, 3'd5:          res = neg_q ? -lo_n : lo_n;
      default:             res = neg_r ? -hi_n : hi_n;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      op         <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      opb        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rd_q       <= '0;
      valid_q    <= 1'b0;
      wdata_q    <= '0;
      regindex_q <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            op     <= f3;
            rd_q   <= bus.de2ex_wr_regindex_ffout;
            acc_hi <= '0;
            acc_lo <= abs_a;
            opb    <= abs_b;
            neg_q  <= (sa & a[XLEN-1]) ^ (sb & b[XLEN-1]);
            neg_r  <= sa & a[XLEN-1];
            if (special) begin
              wdata_q    <= special_res;
              regindex_q <= bus.de2ex_wr_regindex_ffout;
              valid_q    <= 1'b1;
              state      <= DONE;
            end else begin
              cnt   <= CW'(STEPS);
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (bus.ex_flush) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            acc_hi <= hi_n;
            acc_lo <= lo_n;
            cnt    <= cnt - CW'(1);
            if (cnt == CW'(1)) begin
              wdata_q    <= res;
              regindex_q <= rd_q;
              valid_q    <= 1'b1;
              state      <= DONE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.md2ex_busy     = ~reset & (((state == IDLE) & start) | (state == CALC));
  assign bus.md2ex_valid    = valid_q & ~bus.ex_flush;
  assign bus.md2ex_wdata    = wdata_q;
  assign bus.md2ex_regindex = regindex_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: results, latency, busy span, special cases,
// flush, reset mid-op and the UNROLL=4 / XLEN=64 variants.
module tb_ex_muldiv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  ex_muldiv_if #(.XLEN(32)) bus0 ();
  ex_muldiv_if #(.XLEN(32)) bus1 ();
  ex_muldiv_if #(.XLEN(64)) bus2 ();

  ex_muldiv #(.XLEN(32), .UNROLL(1)) u0 (.clk(clk), .reset(reset), .bus(bus0));
  ex_muldiv #(.XLEN(32), .UNROLL(4)) u1 (.clk(clk), .reset(reset), .bus(bus1));
  ex_muldiv #(.XLEN(64), .UNROLL(2)) u2 (.clk(clk), .reset(reset), .bus(bus2));

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive0(input logic v, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] rd);
    bus0.de2ex_inst_valid_ffout  = v;
    bus0.de2ex_MD_OP_ffout       = v;
    bus0.de2ex_aluop_ffout       = op;
    bus0.de2ex_rd_oprand1_ffout  = a;
    bus0.de2ex_rd_oprand2_ffout  = b;
    bus0.de2ex_wr_regindex_ffout = rd;
  endtask

  // Instruction is held while busy (as the stalled pipeline would) and
  // dropped in the valid cycle; consecutive calls are therefore back-to-back.
  task automatic run0(input string tag, input logic [2:0] op, input logic [31:0] a,
                      input logic [31:0] b, input logic [4:0] rd,
                      input logic [31:0] exp, input int exp_lat);
    int cyc;
    int busy_n;
    @(negedge clk);
    drive0(1'b1, op, a, b, rd);
    #1;
    check({tag, "_busy_start"}, 64'(bus0.md2ex_busy), 64'd1);
    busy_n = 1;
    cyc    = 0;
    do begin
      @(negedge clk);
      cyc++;
      if (bus0.md2ex_busy) busy_n++;
    end while (!bus0.md2ex_valid && cyc < 200);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    check({tag, "_busy_span"}, 64'(busy_n), 64'(exp_lat));
    check({tag, "_wdata"}, 64'(bus0.md2ex_wdata), 64'(exp));
    check({tag, "_regindex"}, 64'(bus0.md2ex_regindex), 64'(rd));
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
  endtask

  task automatic run_alt(input string tag, input int sel, input logic [2:0] op,
                         input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] exp, input int exp_lat);
    int   cyc;
    logic v;
    @(negedge clk);
    if (sel == 1) begin
      bus1.de2ex_inst_valid_ffout = 1'b1; bus1.de2ex_MD_OP_ffout = 1'b1;
      bus1.de2ex_aluop_ffout = op; bus1.de2ex_wr_regindex_ffout = 5'd3;
      bus1.de2ex_rd_oprand1_ffout = a[31:0]; bus1.de2ex_rd_oprand2_ffout = b[31:0];
    end else begin
      bus2.de2ex_inst_valid_ffout = 1'b1; bus2.de2ex_MD_OP_ffout = 1'b1;
      bus2.de2ex_aluop_ffout = op; bus2.de2ex_wr_regindex_ffout = 5'd3;
      bus2.de2ex_rd_oprand1_ffout = a; bus2.de2ex_rd_oprand2_ffout = b;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
      v = (sel == 1) ? bus1.md2ex_valid : bus2.md2ex_valid;
    end while (!v && cyc < 200);
    check({tag, "_lat"}, 64'(cyc), 64'(exp_lat));
    if (sel == 1) begin
      check({tag, "_wdata"}, {32'd0, bus1.md2ex_wdata}, exp);
      check({tag, "_regindex"}, 64'(bus1.md2ex_regindex), 64'd3);
      bus1.de2ex_inst_valid_ffout = 1'b0; bus1.de2ex_MD_OP_ffout = 1'b0;
    end else begin
      check({tag, "_wdata"}, bus2.md2ex_wdata, exp);
      check({tag, "_regindex"}, 64'(bus2.md2ex_regindex), 64'd3);
      bus2.de2ex_inst_valid_ffout = 1'b0; bus2.de2ex_MD_OP_ffout = 1'b0;
    end
  endtask

  initial begin
    int vcount;
    reset = 1'b1;
    bus0.ex_flush = 1'b0; bus1.ex_flush = 1'b0; bus2.ex_flush = 1'b0;
    bus1.de2ex_inst_valid_ffout = 1'b0; bus1.de2ex_MD_OP_ffout = 1'b0;
    bus1.de2ex_aluop_ffout = '0; bus1.de2ex_rd_oprand1_ffout = '0;
    bus1.de2ex_rd_oprand2_ffout = '0; bus1.de2ex_wr_regindex_ffout = '0;
    bus2.de2ex_inst_valid_ffout = 1'b0; bus2.de2ex_MD_OP_ffout = 1'b0;
    bus2.de2ex_aluop_ffout = '0; bus2.de2ex_rd_oprand1_ffout = '0;
    bus2.de2ex_rd_oprand2_ffout = '0; bus2.de2ex_wr_regindex_ffout = '0;
    // A start presented during reset must not raise busy.
    drive0(1'b1, 3'd0, 32'd7, 32'd3, 5'd1);
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus0.md2ex_busy), 64'd0);
    check("rst_valid", 64'(bus0.md2ex_valid), 64'd0);
    check("rst_wdata", 64'(bus0.md2ex_wdata), 64'd0);
    check("rst_regindex", 64'(bus0.md2ex_regindex), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    run0("mul_7_m3", 3'd0, 32'd7, 32'hFFFFFFFD, 5'd17, 32'hFFFFFFEB, 33);
    @(negedge clk);
    check("hold_valid", 64'(bus0.md2ex_valid), 64'd0);
    check("hold_wdata", 64'(bus0.md2ex_wdata), 64'hFFFFFFEB);
    check("hold_regindex", 64'(bus0.md2ex_regindex), 64'd17);

    run0("mulhu", 3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd2, 32'hFFFFFFFE, 33);
    run0("mulh", 3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd4, 32'h00000000, 33);
    run0("mulhsu", 3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd6, 32'hFFFFFFFF, 33);
    run0("mul_pos", 3'd0, 32'h12345678, 32'h10, 5'd7, 32'h23456780, 33);
    run0("div_m7_2", 3'd4, 32'hFFFFFFF9, 32'd2, 5'd8, 32'hFFFFFFFD, 33);
    run0("rem_m7_2", 3'd6, 32'hFFFFFFF9, 32'd2, 5'd9, 32'hFFFFFFFF, 33);
    run0("divu_big", 3'd5, 32'h80000000, 32'd3, 5'd10, 32'h2AAAAAAA, 33);
    run0("remu_big", 3'd7, 32'h80000000, 32'd3, 5'd11, 32'h00000002, 33);
    run0("div_100_m7", 3'd4, 32'd100, 32'hFFFFFFF9, 5'd12, 32'hFFFFFFF2, 33);
    run0("rem_100_m7", 3'd6, 32'd100, 32'hFFFFFFF9, 5'd13, 32'h00000002, 33);
    run0("divu_zero", 3'd5, 32'h1234, 32'd0, 5'd14, 32'hFFFFFFFF, 1);
    run0("rem_zero", 3'd6, 32'h1234, 32'd0, 5'd15, 32'h00001234, 1);
    run0("div_ovf", 3'd4, 32'h80000000, 32'hFFFFFFFF, 5'd16, 32'h80000000, 1);
    run0("rem_ovf", 3'd6, 32'h80000000, 32'hFFFFFFFF, 5'd18, 32'h00000000, 1);

    // Flush in CALC cycle 10: no result, then a fresh MUL two cycles later.
    @(negedge clk);
    drive0(1'b1, 3'd0, 32'd5, 32'd5, 5'd20);
    repeat (10) @(negedge clk);
    bus0.ex_flush = 1'b1;
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    #1 check("flush_calc_valid", 64'(bus0.md2ex_valid), 64'd0);
    @(negedge clk);
    bus0.ex_flush = 1'b0;
    #1 check("flush_calc_idle_busy", 64'(bus0.md2ex_busy), 64'd0);
    run0("mul_after_flush", 3'd0, 32'd6, 32'd7, 5'd21, 32'd42, 33);

    // Flush in IDLE suppresses start.
    @(negedge clk);
    drive0(1'b1, 3'd5, 32'd9, 32'd3, 5'd22);
    bus0.ex_flush = 1'b1;
    #1 check("flush_idle_busy", 64'(bus0.md2ex_busy), 64'd0);
    @(negedge clk);
    check("flush_idle_valid", 64'(bus0.md2ex_valid), 64'd0);
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    bus0.ex_flush = 1'b0;

    // Flush in DONE masks the strobe.
    @(negedge clk);
    drive0(1'b1, 3'd5, 32'h55, 32'd0, 5'd23);
    @(negedge clk);
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    bus0.ex_flush = 1'b1;
    #1 check("flush_done_valid", 64'(bus0.md2ex_valid), 64'd0);
    @(negedge clk);
    bus0.ex_flush = 1'b0;

    // Reset mid-CALC abandons the op.
    @(negedge clk);
    drive0(1'b1, 3'd0, 32'd3, 32'd4, 5'd24);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    check("rstcalc_busy", 64'(bus0.md2ex_busy), 64'd0);
    check("rstcalc_wdata", 64'(bus0.md2ex_wdata), 64'd0);
    check("rstcalc_regindex", 64'(bus0.md2ex_regindex), 64'd0);
    @(negedge clk);
    drive0(1'b0, 3'd0, 32'd0, 32'd0, 5'd0);
    @(posedge clk);
    #1 reset = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus0.md2ex_valid) vcount++;
    end
    check("rstcalc_no_valid", 64'(vcount), 64'd0);

    run_alt("u4_mul", 1, 3'd0, 64'd7, 64'hFFFFFFFD, 64'hFFFFFFEB, 9);
    run_alt("u4_div", 1, 3'd4, 64'hFFFFFFF9, 64'd2, 64'hFFFFFFFD, 9);
    run_alt("x64_mul", 2, 3'd0, 64'd7, 64'hFFFFFFFFFFFFFFFD, 64'hFFFFFFFFFFFFFFEB, 33);
    run_alt("x64_mulhu", 2, 3'd3, 64'hFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF,
            64'hFFFFFFFFFFFFFFFE, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/ex_muldiv.md
EX_MULDIV -- requirements
Module: ex_muldiv

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, datapath width; legal values 32 and 64.
REQ-002 The block SHALL have parameter UNROLL, default 1, result bits retired per iteration; legal values 1, 2 and 4; UNROLL divides XLEN.
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports (name  direction  width  meaning):
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- de2ex_inst_valid_ffout  in  1  valid instruction in the execute register.
- de2ex_MD_OP_ffout  in  1  instruction is an M-extension op.
- de2ex_aluop_ffout  in  3  funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- de2ex_rd_oprand1_ffout  in  XLEN  rs1 value.
- de2ex_rd_oprand2_ffout  in  XLEN  rs2 value.
- de2ex_wr_regindex_ffout  in  5  destination register.
- ex_flush  in  1  kill the in-flight op (trap or redirect).
- md2ex_busy  out  1  stall request to the decode/execute pipeline register.
- md2ex_valid  out  1  one-cycle result strobe.
- md2ex_wdata  out  XLEN  result.
- md2ex_regindex  out  5  destination of the result.

Function
REQ-005 start SHALL be de2ex_inst_valid_ffout & de2ex_MD_OP_ffout & !ex_flush.
REQ-006 The FSM SHALL have the states IDLE, CALC and DONE, and reset to IDLE.
REQ-007 In IDLE with start, the block SHALL latch the operands, funct3 and regindex.
- Special case (any divide op with rs2==0, or DIV/REM with rs1==most-negative and rs2==all-ones): go to DONE.
- Otherwise: go to CALC with the iteration counter at XLEN/UNROLL.
REQ-008 CALC SHALL decrement the counter each cycle and go to DONE on the cycle the counter reaches 1, so CALC occupies exactly XLEN/UNROLL cycles.
REQ-009 DONE SHALL last exactly one cycle, assert md2ex_valid, and return to IDLE unconditionally.
- start is not sampled in DONE.
- The stalled instruction is considered consumed in DONE.
REQ-010 md2ex_busy SHALL equal (state==IDLE & start) | (state==CALC), combinationally; it is 0 in DONE so the pipeline advances.
REQ-011 Latency from the start cycle to the valid cycle SHALL be:
- XLEN/UNROLL+1 cycles for normal ops;
- 1 cycle for special-case ops.
REQ-012 Results SHALL follow the RISC-V M definitions on XLEN bits:
- MUL: low XLEN bits of the product.
- MULH / MULHSU / MULHU: high XLEN bits of the 2*XLEN product (signed x signed / signed x unsigned / unsigned x unsigned).
- DIV / DIVU: quotient truncated toward zero.
- REM / REMU: remainder with the sign of the dividend.
REQ-013 Divide-by-zero SHALL give quotient all-ones and remainder = rs1.
REQ-014 Signed overflow (most-negative / -1) SHALL give quotient = most-negative and remainder = 0.
REQ-015 The datapath SHALL be iterative (shift-add multiply, restoring or non-restoring divide), with no XLEN x XLEN combinational multiplier and no combinational divider.
REQ-016 ex_flush asserted in CALC or DONE SHALL return the FSM to IDLE on the next edge, with md2ex_valid=0 in that cycle and no result delivered.
REQ-017 ex_flush asserted in IDLE SHALL suppress start.
REQ-018 md2ex_wdata and md2ex_regindex SHALL be registered, hold their value outside DONE, and change only when entering DONE.
REQ-019 Back-to-back M ops SHALL be supported: the second op starts in the IDLE cycle that follows DONE.

Reset
REQ-020 While reset is high: state=IDLE, counter=0, md2ex_valid=0, md2ex_wdata=0, md2ex_regindex=0, all operand/accumulator registers=0.
REQ-021 md2ex_busy SHALL be 0 during reset.
REQ-022 Reset asserted mid-CALC SHALL abandon the op, and no valid SHALL follow after deassertion.
REQ-023 The first start SHALL be accepted in the first clock cycle after reset deassertion.

Verification
REQ-024 XLEN=32, UNROLL=1, MUL 7 x -3 -> busy for 33 cycles, valid in cycle 34 with wdata=0xFFFFFFEB and regindex echoed.
REQ-025 MULHU 0xFFFFFFFF x 0xFFFFFFFF -> wdata=0xFFFFFFFE; MULH same operands -> wdata=0x00000000.
REQ-026 DIV -7 / 2 -> 0xFFFFFFFD; REM -7 / 2 -> 0xFFFFFFFF; DIVU 0x80000000 / 3 -> 0x2AAAAAAA.
REQ-027 DIVU x / 0 with x=0x1234 -> valid one cycle after start, wdata=0xFFFFFFFF; REM x / 0 -> 0x1234; DIV 0x80000000 / -1 -> 0x80000000 in 1 cycle.
REQ-028 ex_flush in CALC cycle 10 -> IDLE next edge, no valid; a new MUL issued two cycles later completes correctly.
REQ-029 UNROLL=4 -> MUL latency 9 cycles; XLEN=64, UNROLL=2 -> latency 33 cycles; reset pulse in CALC -> outputs 0 and no valid after release.
